// File: rtl/seg_scan_capture_pkg.sv
// seg_scan_capture_pkg: shared row codes, digit count and capture FSM states
// for the 8-digit multiplexed 7-seg scan monitor.
package seg_scan_capture_pkg;
    localparam logic [1:0] ROW_NONE   = 2'b00;
    localparam logic [1:0] ROW_TOP    = 2'b01;
    localparam logic [1:0] ROW_MID    = 2'b10;
    localparam logic [1:0] ROW_BOT    = 2'b11;
    localparam int         NUM_DIGITS = 8;
    typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;
endpackage

// File: rtl/seg_scan_capture_decode.sv
// seg_scan_capture_decode: combinational decode of one COM/segment sample.
// Ports:
//   com_n             in  8  COM lines, active low, bit0 = digit 0
//   seg_a/seg_g/seg_d in  1  row segments, active high
//   blank             out 1  no COM line active
//   multi             out 1  two or more COM lines active
//   index             out 3  active digit (valid when !blank && !multi)
//   seg_err           out 1  two or more segments active
//   code              out 2  row code of the single active segment, 00 if none
module seg_scan_capture_decode
    import seg_scan_capture_pkg::*;
(
    input  logic [NUM_DIGITS-1:0] com_n,
    input  logic                  seg_a,
    input  logic                  seg_g,
    input  logic                  seg_d,
    output logic                  blank,
    output logic                  multi,
    output logic [2:0]            index,
    output logic                  seg_err,
    output logic [1:0]            code
);
    logic [NUM_DIGITS-1:0] low;

    assign low   = ~com_n;
    assign blank = (low == '0);
    // clearing the lowest set bit leaves something only if more than one bit was set
    assign multi = ((low & (low - 8'd1)) != '0);

    always_comb begin
        index = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (low[i]) index = 3'(i);
    end

    assign seg_err = (2'(seg_a) + 2'(seg_g) + 2'(seg_d)) > 2'd1;
    assign code    = seg_d ? ROW_BOT : seg_g ? ROW_MID : seg_a ? ROW_TOP : ROW_NONE;
endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: rebuilds 8-digit frames from a scanned 7-seg link and checks scan order.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   com_n[7:0]               COM lines, active low (bit0 = digit 0)
//   seg_a, seg_g, seg_d      row segments (codes 01, 10, 11)
//   frame[15:0]              last complete frame, digit i at [2i+1:2i]
//   frame_valid              1-cycle pulse when frame updates
//   locked                   high while tracking scan order
//   seq_err                  1-cycle pulse per protocol violation
//   err_count[ERR_CNT_W-1:0] saturating count of seq_err pulses
//   impending                digit1 == digit0 != 0; built only with SEG_SCAN_IMPENDING_EN
module seg_scan_capture
    import seg_scan_capture_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           com_n,
    input  logic                 seg_a,
    input  logic                 seg_g,
    input  logic                 seg_d,
    output logic [15:0]          frame,
    output logic                 frame_valid,
    output logic                 locked,
    output logic                 seq_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 impending
);
    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    logic [7:0]  com_q;
    logic [2:0]  seg_q;
    logic        blank, multi, seg_err, sample_err, same, accept, err, publish;
    logic [2:0]  index, last_idx, expected, expected_nx;
    logic [1:0]  code;
    logic [3:0]  dwell, dwell_nx;
    logic [15:0] shadow, shadow_nx;
    state_t      state, state_nx;

    // idle COM lines reset to all-ones so the first decoded sample is a blank
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            com_q <= '1;
            seg_q <= '0;
        end else begin
            com_q <= com_n;
            seg_q <= {seg_d, seg_g, seg_a};
        end

    seg_scan_capture_decode u_decode (
        .com_n   (com_q),
        .seg_a   (seg_q[0]),
        .seg_g   (seg_q[1]),
        .seg_d   (seg_q[2]),
        .blank   (blank),
        .multi   (multi),
        .index   (index),
        .seg_err (seg_err),
        .code    (code)
    );

    // segment legality only matters while a digit is driven
    assign sample_err = multi | (~blank & seg_err);
    assign same       = (dwell != '0) && (index == last_idx);

    // dwell saturates at SETTLE so each dwell yields exactly one acceptance
    always_comb begin
        dwell_nx = 4'd1;
        if (blank || sample_err)
            dwell_nx = '0;
        else if (same)
            dwell_nx = (dwell == SETTLE) ? dwell : dwell + 4'd1;
        accept = !blank && !sample_err && (dwell_nx == SETTLE) && !(same && dwell == SETTLE);
    end

    always_comb begin
        state_nx    = state;
        expected_nx = expected;
        shadow_nx   = shadow;
        publish     = 1'b0;
        err         = sample_err | (state == TRACK && accept && index != expected);
        if (err) begin
            state_nx    = HUNT;
            expected_nx = '0;
            shadow_nx   = '0;
        end else if (accept) begin
            if (state == HUNT) begin
                if (index == 3'd0) begin
                    state_nx    = TRACK;
                    expected_nx = 3'd1;
                    shadow_nx   = {14'd0, code};
                end
            end else begin
                shadow_nx[{index, 1'b0} +: 2] = code;
                expected_nx = expected + 3'd1;
                publish     = (index == 3'd7);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= HUNT;
            expected <= '0;
            shadow   <= '0;
            dwell    <= '0;
            last_idx <= '0;
        end else begin
            state    <= state_nx;
            expected <= expected_nx;
            shadow   <= shadow_nx;
            dwell    <= dwell_nx;
            if (!blank) last_idx <= index;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            frame       <= '0;
            frame_valid <= 1'b0;
            seq_err     <= 1'b0;
            err_count   <= '0;
        end else begin
            frame_valid <= publish;
            seq_err     <= err;
            if (publish) frame <= shadow_nx;
            if (err && err_count != '1) err_count <= err_count + 1'b1;
        end

    assign locked = (state == TRACK);

`ifdef SEG_SCAN_IMPENDING_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            impending <= 1'b0;
        else if (publish)
            impending <= (shadow_nx[3:2] == shadow_nx[1:0]) && (shadow_nx[1:0] != ROW_NONE);
`else
    assign impending = 1'b0;
`endif
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed self-checking bench for seg_scan_capture (SETTLE 1 and 3).
module tb_seg_scan_capture;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  com_n = 8'hFF;
    logic        seg_a = 1'b0, seg_g = 1'b0, seg_d = 1'b0;
    logic [15:0] frame, frame3;
    logic        frame_valid, locked, seq_err, impending;
    logic        fv3, locked3, se3, imp3;
    logic [7:0]  err_count, ec3;
    int checks = 0, failures = 0;
    int fv_cnt = 0, se_cnt = 0, fv3_cnt = 0, se3_cnt = 0;
    logic [1:0] clean_codes [8] = '{2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
    logic [1:0] b2b_codes   [8] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3};
`ifdef SEG_SCAN_IMPENDING_EN
    localparam bit IMP_ON = 1'b1;
`else
    localparam bit IMP_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    seg_scan_capture #(.SETTLE_CYCLES(1), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .com_n(com_n), .seg_a(seg_a), .seg_g(seg_g), .seg_d(seg_d),
        .frame(frame), .frame_valid(frame_valid), .locked(locked), .seq_err(seq_err),
        .err_count(err_count), .impending(impending)
    );

    seg_scan_capture #(.SETTLE_CYCLES(3), .ERR_CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .com_n(com_n), .seg_a(seg_a), .seg_g(seg_g), .seg_d(seg_d),
        .frame(frame3), .frame_valid(fv3), .locked(locked3), .seq_err(se3),
        .err_count(ec3), .impending(imp3)
    );

    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (seq_err) se_cnt++;
        if (fv3) fv3_cnt++;
        if (se3) se3_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic show(input int k, input logic [1:0] c, input int n);
        com_n = ~(8'd1 << k);
        seg_a = (c == 2'd1);
        seg_g = (c == 2'd2);
        seg_d = (c == 2'd3);
        tick(n);
    endtask

    task automatic gap(input int n);
        com_n = 8'hFF;
        {seg_a, seg_g, seg_d} = 3'b000;
        tick(n);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        gap(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        gap(2);
        checks++; if (frame !== 16'h0) begin failures++; $display("FAIL reset_frame got=%h exp=0000", frame); end
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL reset_seq_err got=%b exp=0", seq_err); end
        checks++; if (err_count !== 8'h0) begin failures++; $display("FAIL reset_err_count got=%h exp=00", err_count); end
        checks++; if (impending !== 1'b0) begin failures++; $display("FAIL reset_impending got=%b exp=0", impending); end
        checks++; if (imp3 !== 1'b0 || locked3 !== 1'b0) begin failures++; $display("FAIL reset_dut3 got=%b%b exp=00", imp3, locked3); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_clean;
        int f0 = fv_cnt;
        int s0 = se_cnt;
        for (int k = 0; k < 8; k++) begin
            show(k, clean_codes[k], 1);
            gap(1);
        end
        gap(2);
        checks++; if (frame !== 16'h010E) begin failures++; $display("FAIL clean_frame got=%h exp=010e", frame); end
        checks++; if (fv_cnt - f0 != 1) begin failures++; $display("FAIL clean_fv_pulses got=%0d exp=1", fv_cnt - f0); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL clean_locked got=%b exp=1", locked); end
        checks++; if (se_cnt - s0 != 0) begin failures++; $display("FAIL clean_seq_err got=%0d exp=0", se_cnt - s0); end
        checks++; if (impending !== 1'b0) begin failures++; $display("FAIL clean_impending got=%b exp=0", impending); end
    endtask

    task automatic test_back_to_back;
        int f0 = fv_cnt;
        int s0 = se_cnt;
        for (int k = 0; k < 8; k++) show(k, b2b_codes[k], 1);
        gap(3);
        checks++; if (frame !== 16'hC00A) begin failures++; $display("FAIL b2b_frame got=%h exp=c00a", frame); end
        checks++; if (fv_cnt - f0 != 1) begin failures++; $display("FAIL b2b_fv_pulses got=%0d exp=1", fv_cnt - f0); end
        checks++; if (se_cnt - s0 != 0) begin failures++; $display("FAIL b2b_seq_err got=%0d exp=0", se_cnt - s0); end
        checks++; if (impending !== IMP_ON) begin failures++; $display("FAIL b2b_impending got=%b exp=%b", impending, IMP_ON); end
    endtask

    task automatic test_mid_scan;
        int f0;
        do_reset();
        f0 = fv_cnt;
        for (int k = 5; k < 8; k++) begin
            show(k, 2'd1, 1);
            gap(1);
        end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL mid_locked_early got=%b exp=0", locked); end
        checks++; if (fv_cnt - f0 != 0 || frame !== 16'h0) begin failures++; $display("FAIL mid_no_frame got=%0d/%h exp=0/0000", fv_cnt - f0, frame); end
        show(0, 2'd1, 1);
        gap(1);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL mid_locked_on_d0 got=%b exp=1", locked); end
        for (int k = 1; k < 8; k++) begin
            show(k, 2'd1, 1);
            gap(1);
        end
        gap(2);
        checks++; if (frame !== 16'h5555) begin failures++; $display("FAIL mid_frame got=%h exp=5555", frame); end
        checks++; if (fv_cnt - f0 != 1) begin failures++; $display("FAIL mid_fv_pulses got=%0d exp=1", fv_cnt - f0); end
    endtask

    task automatic test_out_of_order;
        int f0 = fv_cnt;
        int s0 = se_cnt;
        show(0, 2'd2, 1); gap(1);
        show(1, 2'd2, 1); gap(1);
        show(3, 2'd2, 1); gap(3);
        checks++; if (se_cnt - s0 != 1) begin failures++; $display("FAIL ooo_seq_err got=%0d exp=1", se_cnt - s0); end
        checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL ooo_err_count got=%0d exp=1", err_count); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL ooo_locked got=%b exp=0", locked); end
        checks++; if (frame !== 16'h5555 || fv_cnt != f0) begin failures++; $display("FAIL ooo_frame_kept got=%h/%0d exp=5555/0", frame, fv_cnt - f0); end
    endtask

    task automatic test_illegal;
        com_n = 8'b1111_1100;
        tick(1);
        com_n = 8'hFF;
        checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL com_err_early got=%b exp=0", seq_err); end
        tick(1);
        checks++; if (seq_err !== 1'b1) begin failures++; $display("FAIL com_err_latency got=%b exp=1", seq_err); end
        gap(3);
        checks++; if (err_count !== 8'd2) begin failures++; $display("FAIL com_err_count got=%0d exp=2", err_count); end
        com_n = 8'b1111_1011;
        seg_a = 1'b1;
        seg_g = 1'b1;
        tick(1);
        gap(3);
        checks++; if (err_count !== 8'd3) begin failures++; $display("FAIL seg_err_count got=%0d exp=3", err_count); end
    endtask

    task automatic test_error_wins;
        int f0 = fv_cnt;
        int s0 = se_cnt;
        for (int k = 0; k < 7; k++) begin
            show(k, 2'd1, 1);
            gap(1);
        end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL ew_locked got=%b exp=1", locked); end
        com_n = 8'b0111_1111;
        seg_a = 1'b1;
        seg_d = 1'b1;
        tick(1);
        gap(3);
        checks++; if (fv_cnt - f0 != 0) begin failures++; $display("FAIL ew_no_fv got=%0d exp=0", fv_cnt - f0); end
        checks++; if (se_cnt - s0 != 1 || err_count !== 8'd4) begin failures++; $display("FAIL ew_err got=%0d/%0d exp=1/4", se_cnt - s0, err_count); end
        checks++; if (frame !== 16'h5555 || locked !== 1'b0) begin failures++; $display("FAIL ew_state got=%h/%b exp=5555/0", frame, locked); end
    endtask

    task automatic test_async_reset;
        int f0;
        for (int k = 0; k < 4; k++) begin
            show(k, 2'd3, 1);
            gap(1);
        end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL ar_locked_before got=%b exp=1", locked); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (locked !== 1'b0 || frame !== 16'h0 || err_count !== 8'd0) begin
            failures++; $display("FAIL ar_immediate got=%b/%h/%0d exp=0/0000/0", locked, frame, err_count);
        end
        tick(1);
        rst_n = 1'b1;
        f0 = fv_cnt;
        for (int k = 4; k < 8; k++) begin
            show(k, 2'd3, 1);
            gap(1);
        end
        gap(2);
        checks++; if (fv_cnt - f0 != 0 || frame !== 16'h0) begin failures++; $display("FAIL ar_partial got=%0d/%h exp=0/0000", fv_cnt - f0, frame); end
    endtask

    task automatic test_settle;
        int f3;
        int s3;
        do_reset();
        f3 = fv3_cnt;
        s3 = se3_cnt;
        for (int k = 0; k < 8; k++) begin
            show(k, clean_codes[k], 2);
            gap(1);
        end
        gap(2);
        checks++; if (fv3_cnt - f3 != 0 || locked3 !== 1'b0) begin failures++; $display("FAIL settle_short got=%0d/%b exp=0/0", fv3_cnt - f3, locked3); end
        checks++; if (se3_cnt - s3 != 0) begin failures++; $display("FAIL settle_short_err got=%0d exp=0", se3_cnt - s3); end
        for (int k = 0; k < 8; k++) begin
            show(k, clean_codes[k], 3);
            gap(1);
        end
        gap(2);
        checks++; if (frame3 !== 16'h010E) begin failures++; $display("FAIL settle_frame got=%h exp=010e", frame3); end
        checks++; if (fv3_cnt - f3 != 1 || locked3 !== 1'b1) begin failures++; $display("FAIL settle_fv got=%0d/%b exp=1/1", fv3_cnt - f3, locked3); end
        checks++; if (se3_cnt - s3 != 0) begin failures++; $display("FAIL settle_err got=%0d exp=0", se3_cnt - s3); end
    endtask

    task automatic test_saturate;
        com_n = 8'h00;
        tick(300);
        gap(3);
        checks++; if (err_count !== 8'hFF) begin failures++; $display("FAIL sat_err_count got=%0d exp=255", err_count); end
        checks++; if (ec3 !== 8'hFF) begin failures++; $display("FAIL sat_err_count3 got=%0d exp=255", ec3); end
        checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL sat_seq_err_idle got=%b exp=0", seq_err); end
        do_reset();
        checks++; if (err_count !== 8'h0) begin failures++; $display("FAIL sat_reset got=%0d exp=0", err_count); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_back_to_back();
        test_mid_scan();
        test_out_of_order();
        test_illegal();
        test_error_wins();
        test_async_reset();
        test_settle();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
